ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction-fetch initiator for the read port of the unified byte-addressed RAM.
//  Drives the RAM read address and captures the 32-bit little-endian word the RAM returns one cycle later.
//  Buffers fetched words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
//  Sits between the RAM (port a) and the decode stage; branch/jump redirects come from execute.
// PARAMETERS
//  ADDR_WIDTH  16  byte-address width; matches the RAM address width
//  DATA_WIDTH  32  instruction word width; fixed at 32 (4 bytes per fetch)
//  FIFO_DEPTH  4   instruction-buffer entries; power of two, >=2
//  RESET_PC    0   first fetch address after reset
// PORTS
//  clk             in   1           system clock, rising edge
//  rst_n           in   1           asynchronous active-low reset
//  mem_addr        out  ADDR_WIDTH  RAM read address; RAM registers it, data on mem_dout next cycle
//  mem_dout        in   DATA_WIDTH  RAM read data for the address presented the previous cycle
//  redirect_valid  in   1           single-cycle pulse: flush and restart fetch at redirect_pc
//  redirect_pc     in   ADDR_WIDTH  new fetch address; bits [1:0] are forced to 0
//  out_valid       out  1           out_inst/out_pc hold a valid entry
//  out_ready       in   1           decode accepts the entry when out_valid && out_ready
//  out_inst        out  DATA_WIDTH  instruction word at FIFO head
//  out_pc          out  ADDR_WIDTH  byte address of out_inst
// BEHAVIOUR
//  - Reset (async assert, sync release): fetch_pc=RESET_PC, FIFO empty, inflight=0.
//    Outputs under reset: out_valid=0, out_inst=0, out_pc=0, mem_addr=RESET_PC.
//  - mem_addr = fetch_pc (combinational from the register).
//  - Issue cycle: issue = !redirect_valid && (count + inflight < FIFO_DEPTH).
//    On issue: fetch_pc <= fetch_pc + 4 (wraps mod 2^ADDR_WIDTH); inflight <= 1; issued PC is latched.
//    Otherwise fetch_pc holds and inflight <= 0.
//  - Response cycle: when inflight=1 (and no redirect this cycle), push {mem_dout, latched PC} into the FIFO.
//    The credit check guarantees the push never overflows.
//  - Pop: on out_valid && out_ready. Push and pop in the same cycle are allowed at any occupancy, including full.
//  - Latency: PC issued in cycle N -> FIFO write at end of N+1 -> out_valid in N+2. No bypass.
//    Steady state with out_ready=1 delivers 1 instruction per cycle.
//  - out_inst/out_pc are stable while out_valid=1 && out_ready=0.
//  - Redirect cycle:
//    - FIFO cleared, inflight cleared, the in-flight response is discarded, no issue, no pop.
//    - fetch_pc <= {redirect_pc[AW-1:2],2'b00}.
//    - out_valid=0 from the next cycle; the first instruction from the new PC appears 3 cycles after the pulse.
//  - Redirect has priority over push, pop and issue in the same cycle.
//  - Back-to-back redirects: the last one wins; each restarts the 3-cycle latency.
//  - Wrap: PC 0xFFFC (AW=16) is followed by 0x0000. RAM-side address wrap is the RAM's concern.
//  - Reset mid-operation: all state returns to reset values immediately; no partial push survives.
// STRUCTURE
//  - Shared package: INST_BYTES=4, NOP word 32'h00000013, FIFO-entry typedef {pc, inst}.
//  - Sub-module ifetch_fifo: synchronous FIFO with count output, sync clear, async active-low reset.
//    Write-first is not required; a simultaneous push+pop when full is legal.
//  - Top level: PC register, inflight flag and latched PC, credit check, redirect control.
// TESTING
//  1. Reset release, RAM preloaded with 0x00000001,0x00000002,... at 0x0,0x4,...; out_ready=1
//     -> out_valid first high 2 cycles after release with pc=0x0, inst=1; then pc=0x4, inst=2 on consecutive cycles.
//  2. out_ready=0 for 10 cycles -> FIFO fills to 4; mem_addr stops advancing at 0x10; out_pc holds 0x0.
//     Release -> pcs 0x0..0x1C in order, no gap, no duplicates.
//  3. Redirect pulse to 0x0102 while FIFO holds 3 entries
//     -> next cycle out_valid=0, mem_addr=0x0100; first output pc=0x0100 exactly 3 cycles after the pulse.
//  4. Redirect to 0xFFF8 (AW=16) -> outputs pc 0xFFF8, 0xFFFC, 0x0000, 0x0004.
//  5. FIFO full with push+pop every cycle (out_ready=1 after fill) -> 1 instruction per cycle, count stays <=4, no lost word.
//  6. rst_n asserted mid-stream with inflight=1 -> out_valid=0 immediately; after release, refetch starts at RESET_PC.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch unit.
// Entry layout is {pc, inst} so the PC sits in the upper bits of a packed entry.
package ifetch_unit_pkg;

    localparam int INST_BYTES = 4;
    localparam int INST_WIDTH = 32;
    localparam int PC_WIDTH   = 16;

    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous instruction buffer with occupancy count and synchronous clear.
// Push and pop may coincide at any occupancy; clear wins over both.
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count_q;
    logic             pop_ok;

    assign pop_ok = pop && (count_q != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the processes run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; a slot is only observed after it has been
    // written, so resetting it would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: drives the RAM read address, captures the word
// one cycle later, buffers {pc, inst} pairs and hands them to decode.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = PC_WIDTH,
    parameter int                    DATA_WIDTH = INST_WIDTH,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam int                    CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]           DEPTH_C   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(INST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MSK = ~ADDR_WIDTH'(INST_BYTES - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] issued_pc;
    logic                  inflight;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic [CW-1:0]         count;
    logic [CW:0]           credits_used;
    entry_t                wr_entry;
    entry_t                rd_entry;

    // A slot is reserved at issue time, so the response push can never overflow.
    assign credits_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue        = !redirect_valid && (credits_used < DEPTH_C);
    assign push         = inflight && !redirect_valid;
    assign pop          = out_valid && out_ready && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= RESET_PC;
            inflight  <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc  <= redirect_pc & ALIGN_MSK;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc  <= fetch_pc + PC_STEP;
                issued_pc <= fetch_pc;
            end
        end
    end

    assign wr_entry = '{pc: issued_pc, inst: mem_dout};

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (redirect_valid),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign mem_addr  = fetch_pc;
    assign out_valid = !fifo_empty;
    // Gating keeps never-written storage off the outputs while empty.
    assign out_inst  = out_valid ? rd_entry.inst : '0;
    assign out_pc    = out_valid ? rd_entry.pc   : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit with a one-cycle-latency RAM model
// whose word at byte address a is (a >> 2) + 1.
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic [31:0] mem_dout;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [15:0] out_pc;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ifetch_unit #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_dout       (mem_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    always @(posedge clk) mem_dout <= 32'(mem_addr[15:2]) + 32'd1;

    function automatic logic [31:0] word_at(input logic [15:0] pc);
        return 32'(pc[15:2]) + 32'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        #2;
        tests_run++;
        if ({out_valid, out_pc, out_inst, mem_addr} !== {1'b0, 16'h0, 32'h0, 16'h0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b pc=%h inst=%h addr=%h, expected 0/0000/00000000/0000",
                     out_valid, out_pc, out_inst, mem_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_latency_e0: got valid=%b, expected 0", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_pc;
            exp_pc = 16'(i * 4);
            tick();
            tests_run++;
            if ({out_valid, out_pc, out_inst} !== {1'b1, exp_pc, word_at(exp_pc)}) begin
                tests_failed++;
                $display("FAIL reset_stream[%0d]: got valid=%b pc=%h inst=%h, expected 1/%h/%h",
                         i, out_valid, out_pc, out_inst, exp_pc, word_at(exp_pc));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (10) tick();
        tests_run++;
        if ({mem_addr, out_valid, out_pc, out_inst} !== {16'h0010, 1'b1, 16'h0000, 32'h1}) begin
            tests_failed++;
            $display("FAIL stall_hold: got addr=%h valid=%b pc=%h inst=%h, expected 0010/1/0000/00000001",
                     mem_addr, out_valid, out_pc, out_inst);
        end
        tick();
        tests_run++;
        if ({mem_addr, out_pc} !== {16'h0010, 16'h0000}) begin
            tests_failed++;
            $display("FAIL stall_stable: got addr=%h pc=%h, expected 0010/0000", mem_addr, out_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp_pc;
            exp_pc = 16'(i * 4);
            tests_run++;
            if ({out_valid, out_pc, out_inst} !== {1'b1, exp_pc, word_at(exp_pc)}) begin
                tests_failed++;
                $display("FAIL drain[%0d]: got valid=%b pc=%h inst=%h, expected 1/%h/%h",
                         i, out_valid, out_pc, out_inst, exp_pc, word_at(exp_pc));
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (4) tick();
        tests_run++;
        if ({out_valid, out_pc} !== {1'b1, 16'h0000}) begin
            tests_failed++;
            $display("FAIL redirect_setup: got valid=%b pc=%h, expected 1/0000", out_valid, out_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0102;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tests_run++;
        if ({out_valid, mem_addr} !== {1'b0, 16'h0100}) begin
            tests_failed++;
            $display("FAIL redirect_flush: got valid=%b addr=%h, expected 0/0100", out_valid, mem_addr);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redirect_gap: got valid=%b, expected 0", out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            logic [15:0] exp_pc;
            exp_pc = 16'h0100 + 16'(i * 4);
            tick();
            tests_run++;
            if ({out_valid, out_pc, out_inst} !== {1'b1, exp_pc, word_at(exp_pc)}) begin
                tests_failed++;
                $display("FAIL redirect_out[%0d]: got valid=%b pc=%h inst=%h, expected 1/%h/%h",
                         i, out_valid, out_pc, out_inst, exp_pc, word_at(exp_pc));
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pcs [4];
        exp_pcs = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({out_valid, out_pc, out_inst} !== {1'b1, exp_pcs[i], word_at(exp_pcs[i])}) begin
                tests_failed++;
                $display("FAIL wrap[%0d]: got valid=%b pc=%h inst=%h, expected 1/%h/%h",
                         i, out_valid, out_pc, out_inst, exp_pcs[i], word_at(exp_pcs[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        tick();
        tests_run++;
        if ({out_valid, mem_addr} !== {1'b0, 16'h0200}) begin
            tests_failed++;
            $display("FAIL b2b_first: got valid=%b addr=%h, expected 0/0200", out_valid, mem_addr);
        end
        redirect_pc = 16'h0303;
        tick();
        redirect_valid = 1'b0;
        tests_run++;
        if ({out_valid, mem_addr} !== {1'b0, 16'h0300}) begin
            tests_failed++;
            $display("FAIL b2b_second: got valid=%b addr=%h, expected 0/0300", out_valid, mem_addr);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_gap: got valid=%b, expected 0", out_valid);
        end
        tick();
        tests_run++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 16'h0300, word_at(16'h0300)}) begin
            tests_failed++;
            $display("FAIL b2b_out: got valid=%b pc=%h inst=%h, expected 1/0300/%h",
                     out_valid, out_pc, out_inst, word_at(16'h0300));
        end
    endtask

    task automatic test_full_throughput();
        fetch_entry_t exp_e;
        int           waited;
        do_reset();
        repeat (6) tick();
        out_ready = 1'b1;
        waited    = 0;
        while (!out_valid && waited < 10) begin
            tick();
            waited++;
        end
        for (int i = 0; i < 16; i++) begin
            exp_e.pc   = 16'(i * 4);
            exp_e.inst = word_at(exp_e.pc);
            tests_run++;
            if ({out_valid, out_pc, out_inst} !== {1'b1, exp_e}) begin
                tests_failed++;
                $display("FAIL throughput[%0d]: got valid=%b pc=%h inst=%h, expected 1/%h/%h",
                         i, out_valid, out_pc, out_inst, exp_e.pc, exp_e.inst);
            end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_pc, out_inst, mem_addr} !== {1'b0, 16'h0, 32'h0, 16'h0}) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got valid=%b pc=%h inst=%h addr=%h, expected 0/0000/00000000/0000",
                     out_valid, out_pc, out_inst, mem_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_latency: got valid=%b, expected 0", out_valid);
        end
        tick();
        tests_run++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 16'h0000, 32'h1}) begin
            tests_failed++;
            $display("FAIL midreset_refetch: got valid=%b pc=%h inst=%h, expected 1/0000/00000001",
                     out_valid, out_pc, out_inst);
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_full_throughput();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
